uart_cmd_dispatcher: RTL

Command sequencer between the UART n-byte frame receiver and the SPI master. It queues validated 4-byte command frames, decodes each one, and runs the SPI transaction it names. It then returns a status response, plus read data where the command has any, through the UART transmitter's byte handshake. This is the only block that drives the SPI master's request port.

---
 rtl/uart_cmd_dispatcher.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_dispatcher.sv
// Command sequencer: queues validated 4-byte UART frames, runs the named SPI transaction
// and streams the status/read-data response to the UART transmitter. Optional: DISPATCH_TIMEOUT_EN.
module uart_cmd_dispatcher #(
   parameter int FIFO_AW     = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] frame_data_i,
   input  logic        frame_valid_i,
   input  logic        frame_ok_i,
   output logic        spi_req_o,
   output logic        spi_wr_o,
   output logic [7:0]  spi_addr_o,
   output logic [15:0] spi_wdata_o,
   input  logic        spi_ack_i,
   input  logic [15:0] spi_rdata_i,
   output logic        tx_valid_o,
   output logic [7:0]  tx_data_o,
   input  logic        tx_ready_i,
   output logic        busy_o,
   output logic [7:0]  drop_cnt_o,
   output logic [7:0]  err_cnt_o
);

   localparam int DEPTH = 2 ** FIFO_AW;

   typedef enum logic [1:0] {IDLE, DECODE, SPI_REQ, RSP} state_t;

   state_t              state_reg, state_next;
   logic [31:0]         fifo_mem [DEPTH];
   logic [31:0]         cmd_reg;
   logic [FIFO_AW-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [FIFO_AW:0]    count_reg;
   logic                full, empty, push, pop;
   logic                bad_frame, drop_frame, fsm_err;
   logic [1:0]          err_inc;
   logic [8:0]          err_sum;
   logic [7:0]          drop_reg, err_reg;
   logic                spi_req_reg, spi_req_next;
   logic                spi_wr_reg, spi_wr_next;
   logic [7:0]          spi_addr_reg, spi_addr_next;
   logic [15:0]         spi_wdata_reg, spi_wdata_next;
   logic [23:0]         rsp_reg, rsp_next;
   logic [1:0]          len_reg, len_next;
   logic [1:0]          idx_reg, idx_next;
   logic                tx_valid_reg, tx_valid_next;
   logic [7:0]          tx_data_reg, tx_data_next;
   logic                busy_reg;
   logic [7:0]          rsp_bytes [3];
`ifdef DISPATCH_TIMEOUT_EN
   logic [15:0]         tmo_reg, tmo_next;
`endif

   // Occupancy is registered, so a pop in the same cycle never frees room for a push.
   assign full       = (count_reg == (FIFO_AW + 1)'(DEPTH));
   assign empty      = (count_reg == '0);
   assign bad_frame  = frame_valid_i && !frame_ok_i;
   assign drop_frame = frame_valid_i && frame_ok_i && full;
   assign push       = frame_valid_i && frame_ok_i && !full;

   // Byte 0 of a response is always the top byte of rsp_reg.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_rsp_byte
         assign rsp_bytes[gi] = rsp_reg[23 - 8 * gi -: 8];
      end
   endgenerate

   // Storage and head read carry no reset so they map onto RAM with a registered read.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= frame_data_i;
      end
      if (pop) begin
         cmd_reg <= fifo_mem[rd_ptr_reg];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_comb begin
      state_next     = state_reg;
      spi_req_next   = spi_req_reg;
      spi_wr_next    = spi_wr_reg;
      spi_addr_next  = spi_addr_reg;
      spi_wdata_next = spi_wdata_reg;
      rsp_next       = rsp_reg;
      len_next       = len_reg;
      idx_next       = idx_reg;
      tx_valid_next  = tx_valid_reg;
      tx_data_next   = tx_data_reg;
      pop            = 1'b0;
      fsm_err        = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      tmo_next       = '0;
`endif
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = DECODE;
            end
         end
         DECODE: begin
            idx_next = '0;
            case (cmd_reg[31:24])
               8'h01, 8'h02: begin
                  spi_req_next   = 1'b1;
                  spi_wr_next    = (cmd_reg[31:24] == 8'h01);
                  spi_addr_next  = cmd_reg[23:16];
                  spi_wdata_next = cmd_reg[15:0];
                  state_next     = SPI_REQ;
               end
               8'h03: begin
                  rsp_next   = {8'hA5, cmd_reg[15:0]};
                  len_next   = 2'd3;
                  state_next = RSP;
               end
               default: begin
                  rsp_next   = {8'hE1, 16'h0000};
                  len_next   = 2'd1;
                  fsm_err    = 1'b1;
                  state_next = RSP;
               end
            endcase
         end
         SPI_REQ: begin
            if (spi_ack_i) begin
               spi_req_next = 1'b0;
               if (spi_wr_reg) begin
                  rsp_next = {8'hA5, 16'h0000};
                  len_next = 2'd1;
               end else begin
                  rsp_next = {8'hA5, spi_rdata_i};
                  len_next = 2'd3;
               end
               state_next = RSP;
            end
`ifdef DISPATCH_TIMEOUT_EN
            else if (tmo_reg == 16'(TIMEOUT_CYC - 1)) begin
               spi_req_next = 1'b0;
               rsp_next     = {8'hE2, 16'h0000};
               len_next     = 2'd1;
               fsm_err      = 1'b1;
               state_next   = RSP;
            end else begin
               tmo_next = tmo_reg + 16'd1;
            end
`endif
         end
         RSP: begin
            // tx_valid is low only on the first RSP cycle; it stays high between bytes.
            if (!tx_valid_reg) begin
               tx_valid_next = 1'b1;
               tx_data_next  = rsp_bytes[idx_reg];
            end else if (tx_ready_i) begin
               if (idx_reg == len_reg - 2'd1) begin
                  tx_valid_next = 1'b0;
                  idx_next      = '0;
                  state_next    = IDLE;
               end else begin
                  idx_next     = idx_reg + 2'd1;
                  tx_data_next = rsp_bytes[idx_reg + 2'd1];
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign err_inc = {1'b0, bad_frame} + {1'b0, fsm_err};
   assign err_sum = {1'b0, err_reg} + {7'd0, err_inc};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg     <= IDLE;
         spi_req_reg   <= 1'b0;
         spi_wr_reg    <= 1'b0;
         spi_addr_reg  <= '0;
         spi_wdata_reg <= '0;
         rsp_reg       <= '0;
         len_reg       <= '0;
         idx_reg       <= '0;
         tx_valid_reg  <= 1'b0;
         tx_data_reg   <= '0;
         busy_reg      <= 1'b0;
         drop_reg      <= '0;
         err_reg       <= '0;
`ifdef DISPATCH_TIMEOUT_EN
         tmo_reg       <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         spi_req_reg   <= spi_req_next;
         spi_wr_reg    <= spi_wr_next;
         spi_addr_reg  <= spi_addr_next;
         spi_wdata_reg <= spi_wdata_next;
         rsp_reg       <= rsp_next;
         len_reg       <= len_next;
         idx_reg       <= idx_next;
         tx_valid_reg  <= tx_valid_next;
         tx_data_reg   <= tx_data_next;
         busy_reg      <= (state_next != IDLE);
         if (drop_frame && drop_reg != 8'hFF) begin
            drop_reg <= drop_reg + 8'd1;
         end
         err_reg       <= err_sum[8] ? 8'hFF : err_sum[7:0];
`ifdef DISPATCH_TIMEOUT_EN
         tmo_reg       <= tmo_next;
`endif
      end
   end

   assign spi_req_o   = spi_req_reg;
   assign spi_wr_o    = spi_wr_reg;
   assign spi_addr_o  = spi_addr_reg;
   assign spi_wdata_o = spi_wdata_reg;
   assign tx_valid_o  = tx_valid_reg;
   assign tx_data_o   = tx_data_reg;
   assign busy_o      = busy_reg;
   assign drop_cnt_o  = drop_reg;
   assign err_cnt_o   = err_reg;

endmodule
